// File: rtl/md_pad_scanner.sv
// md_pad_scanner: DB9 SELECT sequencer and sampler for Mega Drive 3/6-button
// pads and Atari-style sticks, producing a per-frame atomic button word.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   scan_req    one-cycle scan request (frame tick); ignored while busy
//   db9_pins    raw pins, active low {pin9,pin6,up,down,left,right}
//   db9_sel     SELECT drive (pin7)
//   buttons     active high {mode,x,y,z,start,a,c,b,up,down,left,right}
//   db9joy_out  active low {btn2=C,fire=B,up,down,left,right}
//   md_pad      Mega Drive pad seen on last scan
//   six_btn     6-button pad seen on last scan
//   valid       one-cycle pulse when outputs update
//   busy        high from scan acceptance until the idle gap ends

module md_pad_scanner #(
  parameter int unsigned HALF_CYCLES = 280,
  parameter int unsigned GAP_CYCLES  = 56000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_req,
  input  logic [5:0]  db9_pins,
  output logic        db9_sel,
  output logic [11:0] buttons,
  output logic [5:0]  db9joy_out,
  output logic        md_pad,
  output logic        six_btn,
  output logic        valid,
  output logic        busy
);

  if (HALF_CYCLES < 4 || HALF_CYCLES > 65535) begin : g_bad_half
    $error("md_pad_scanner: HALF_CYCLES out of range 4..65535");
  end

  if (GAP_CYCLES < 1 || GAP_CYCLES > 65535) begin : g_bad_gap
    $error("md_pad_scanner: GAP_CYCLES out of range 1..65535");
  end

  localparam logic [15:0] HALF_LAST = 16'(HALF_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PHASE,
    S_GAP
  } state_t;

  // pin synchronizer
  logic [5:0] r_sync1;
  logic [5:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 6'h3F;
      r_sync2 <= 6'h3F;
    end else begin
      r_sync1 <= db9_pins;
      r_sync2 <= r_sync1;
    end
  end

  // sequencer state
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_phase;

  // shadow registers, only visible after a full scan
  logic [3:0]  r_dir;
  logic        r_b;
  logic        r_c;
  logic        r_a;
  logic        r_st;
  logic        r_md;
  logic        r_six;
  logic [3:0]  r_mxyz;

  // registered outputs
  logic        r_sel;
  logic [11:0] r_buttons;
  logic [5:0]  r_joy;
  logic        r_md_pad;
  logic        r_six_btn;
  logic        r_valid;
  logic        r_busy;

  logic [5:0]  w_s;
  logic        w_phase_end;
  logic        w_gap_end;
  logic [2:0]  w_next_phase;
  logic        w_six_ok;
  logic [11:0] w_commit_btn;
  logic [5:0]  w_commit_joy;

  assign w_s          = r_sync2;
  assign w_phase_end  = (r_cnt == HALF_LAST);
  assign w_gap_end    = (r_cnt == GAP_LAST);
  assign w_next_phase = r_phase + 3'd1;

  // Atari sticks carry only directions, B and C; the extra
  // 6-button bits are trusted only when both handshakes matched
  assign w_six_ok = r_md & r_six;

  assign w_commit_btn = {
    w_six_ok ? r_mxyz : 4'b0000,
    r_md ? r_st : 1'b0,
    r_md ? r_a : 1'b0,
    r_c,
    r_b,
    r_dir
  };

  assign w_commit_joy = ~{r_c, r_b, r_dir};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_phase   <= 3'd0;
      r_dir     <= 4'd0;
      r_b       <= 1'b0;
      r_c       <= 1'b0;
      r_a       <= 1'b0;
      r_st      <= 1'b0;
      r_md      <= 1'b0;
      r_six     <= 1'b0;
      r_mxyz    <= 4'd0;
      r_sel     <= 1'b1;
      r_buttons <= 12'h000;
      r_joy     <= 6'h3F;
      r_md_pad  <= 1'b0;
      r_six_btn <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_sel <= 1'b1;
          if (scan_req) begin
            r_state <= S_PHASE;
            r_phase <= 3'd0;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b1;
          end
        end

        S_PHASE: begin
          if (w_phase_end) begin
            // sample at the last cycle of the phase, when the
            // pad has long settled on the current SELECT level
            case (r_phase)
              3'd0: begin
                r_dir <= ~w_s[3:0];
                r_b   <= ~w_s[4];
                r_c   <= ~w_s[5];
              end
              3'd1: begin
                r_md <= (w_s[1:0] == 2'b00);
                r_a  <= ~w_s[4];
                r_st <= ~w_s[5];
              end
              3'd5: begin
                r_six <= (w_s[3:0] == 4'b0000);
              end
              3'd6: begin
                r_mxyz <= {~w_s[0], ~w_s[1], ~w_s[2], ~w_s[3]};
              end
              default: begin
              end
            endcase

            r_cnt <= 16'd0;

            if (r_phase == 3'd7) begin
              r_buttons <= w_commit_btn;
              r_joy     <= w_commit_joy;
              r_md_pad  <= r_md;
              r_six_btn <= w_six_ok;
              r_valid   <= 1'b1;
              r_sel     <= 1'b1;
              r_state   <= S_GAP;
            end else begin
              r_phase <= w_next_phase;
              r_sel   <= ~w_next_phase[0];
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_GAP: begin
          // long SELECT-high idle lets 6-button pads
          // reset their internal toggle counter
          r_sel <= 1'b1;
          if (w_gap_end) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 16'd0;
          r_sel   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign db9_sel    = r_sel;
  assign buttons    = r_buttons;
  assign db9joy_out = r_joy;
  assign md_pad     = r_md_pad;
  assign six_btn    = r_six_btn;
  assign valid      = r_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_md_pad_scanner.sv
// tb_md_pad_scanner: self-checking bench with a behavioural pad model
// (Atari stick, 3-button, 6-button) driven from the SELECT line.

module tb_md_pad_scanner;

  localparam int H = 8;
  localparam int G = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_req = 1'b0;
  logic [5:0]  db9_pins;
  logic        db9_sel;
  logic [11:0] buttons;
  logic [5:0]  db9joy_out;
  logic        md_pad;
  logic        six_btn;
  logic        valid;
  logic        busy;

  always #5 clk = ~clk;

  md_pad_scanner #(
    .HALF_CYCLES(H),
    .GAP_CYCLES(G)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scan_req(scan_req),
    .db9_pins(db9_pins),
    .db9_sel(db9_sel),
    .buttons(buttons),
    .db9joy_out(db9joy_out),
    .md_pad(md_pad),
    .six_btn(six_btn),
    .valid(valid),
    .busy(busy)
  );

  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;
  int nvalid = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid) nvalid <= nvalid + 1;

  // pad model: 0 = Atari, 1 = 3-button, 2 = 6-button
  int          pad_type = 0;
  logic [11:0] pad_btn = 12'h000;
  int          e = 0;
  int          hi = 0;
  logic        psel = 1'b1;

  // count SELECT toggles; a long SELECT-high idle resets the count
  always @(posedge clk) begin
    psel <= db9_sel;
    if (db9_sel != psel) begin
      e  <= e + 1;
      hi <= 0;
    end else if (db9_sel) begin
      if (hi > 20) e <= 0;
      else hi <= hi + 1;
    end
  end

  // b = {mode,x,y,z,start,a,c,b,up,down,left,right}, active high
  function automatic logic [5:0] pad_pins(int t, logic [11:0] b,
                                          int ev, logic sel);
    logic [5:0] p;
    p = ~b[5:0];
    if (t != 0) begin
      if (sel) begin
        if (t == 2 && ev == 6)
          p = ~{b[5], b[4], b[8], b[9], b[10], b[11]};
      end else begin
        if (t == 2 && ev == 5)
          p = {~b[7], ~b[6], 4'b0000};
        else if (t == 2 && ev == 7)
          p = {~b[7], ~b[6], 4'b1111};
        else
          p = {~b[7], ~b[6], ~b[3], ~b[2], 2'b00};
      end
    end
    return p;
  endfunction

  assign db9_pins = pad_pins(pad_type, pad_btn, e, db9_sel);

  function automatic logic [11:0] legal(logic [11:0] b);
    logic [11:0] r;
    r = b;
    if (r[3] && r[2]) r[2] = 1'b0;
    if (r[1] && r[0]) r[0] = 1'b0;
    return r;
  endfunction

  function automatic logic [11:0] exp_btn(int t, logic [11:0] b);
    if (t == 0) return b & 12'h03F;
    if (t == 1) return b & 12'h0FF;
    return b;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_scan(string nm, int t, logic [11:0] b,
                          logic [11:0] eb, logic [5:0] ej,
                          logic emd, logic esix,
                          logic [11:0] b_late, int late_e);
    logic [19:0] old;
    int acc;
    int lat;
    bit got;
    bit early;
    pad_type = t;
    pad_btn  = b;
    @(negedge clk);
    old = {buttons, db9joy_out, md_pad, six_btn};
    scan_req = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    scan_req = 1'b0;
    chk({nm, ".busy_hi"}, 32'(busy), 32'd1);
    got = 0;
    early = 0;
    lat = 0;
    for (int k = 0; k < 8 * H + 20 && !got; k++) begin
      @(negedge clk);
      if (late_e >= 0 && e == late_e) pad_btn = b_late;
      if (valid) begin
        got = 1;
        lat = cyc - acc;
      end else if ({buttons, db9joy_out, md_pad, six_btn} !== old) begin
        early = 1;
      end
    end
    chk({nm, ".valid_seen"}, 32'(got), 32'd1);
    chk({nm, ".latency_ok"},
        32'(lat >= 8 * H - 1 && lat <= 8 * H + 1), 32'd1);
    chk({nm, ".no_early_change"}, 32'(early), 32'd0);
    chk({nm, ".buttons"}, 32'(buttons), 32'(eb));
    chk({nm, ".db9joy"}, 32'(db9joy_out), 32'(ej));
    chk({nm, ".md_pad"}, 32'(md_pad), 32'(emd));
    chk({nm, ".six_btn"}, 32'(six_btn), 32'(esix));
    @(negedge clk);
    chk({nm, ".valid_1cyc"}, 32'(valid), 32'd0);
    got = 0;
    for (int k = 0; k < G + 20 && !got; k++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    chk({nm, ".busy_fall"}, 32'(got), 32'd1);
  endtask

  typedef struct {
    int          ptype;
    logic [11:0] btn;
    logic [11:0] eb;
    logic [5:0]  ej;
    logic        emd;
    logic        esix;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int nv;
    bit got;
    logic [11:0] rb;
    int rt;

    tbl[0] = '{0, 12'h021, 12'h021, 6'b011110, 1'b0, 1'b0};
    tbl[1] = '{1, 12'h058, 12'h058, 6'b100111, 1'b1, 1'b0};
    tbl[2] = '{2, 12'h900, 12'h900, 6'h3F,     1'b1, 1'b1};
    tbl[3] = '{1, 12'hEA6, 12'h0A6, 6'b011001, 1'b1, 1'b0};
    tbl[4] = '{0, 12'hFD9, 12'h019, 6'b100110, 1'b0, 1'b0};
    tbl[5] = '{2, 12'hFFA, 12'hFFA, 6'b000101, 1'b1, 1'b1};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst.sel", 32'(db9_sel), 32'd1);
    chk("rst.buttons", 32'(buttons), 32'h000);
    chk("rst.db9joy", 32'(db9joy_out), 32'h3F);
    chk("rst.md_six", 32'({md_pad, six_btn}), 32'd0);
    chk("rst.valid_busy", 32'({valid, busy}), 32'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_scan($sformatf("tbl%0d", i), tbl[i].ptype, tbl[i].btn,
               tbl[i].eb, tbl[i].ej, tbl[i].emd, tbl[i].esix,
               12'h000, -1);

    // reset in the middle of phase 3
    pad_type = 2;
    pad_btn  = 12'hFFA;
    @(negedge clk);
    scan_req = 1'b1;
    @(posedge clk);
    #1;
    scan_req = 1'b0;
    got = 0;
    for (int k = 0; k < 8 * H && !got; k++) begin
      @(negedge clk);
      if (e == 3) got = 1;
    end
    chk("midrst.reach_p3", 32'(got), 32'd1);
    #1;
    nv = nvalid;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.sel", 32'(db9_sel), 32'd1);
    chk("midrst.buttons", 32'(buttons), 32'h000);
    chk("midrst.db9joy", 32'(db9joy_out), 32'h3F);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.md_six", 32'({md_pad, six_btn}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8 * H + G + 40) @(negedge clk);
    #1;
    chk("midrst.no_valid", 32'(nvalid), 32'(nv));
    chk("midrst.idle", 32'({busy, buttons}), 32'd0);

    // requests while busy are dropped
    pad_type = 1;
    pad_btn  = 12'h058;
    #1;
    nv = nvalid;
    @(negedge clk);
    scan_req = 1'b1;
    @(posedge clk);
    #1;
    scan_req = 1'b0;
    repeat (4) @(negedge clk);
    scan_req = 1'b1;
    @(negedge clk);
    scan_req = 1'b0;
    got = 0;
    for (int k = 0; k < 8 * H + 20 && !got; k++) begin
      @(negedge clk);
      if (valid) got = 1;
    end
    chk("ign.valid_seen", 32'(got), 32'd1);
    repeat (10) @(negedge clk);
    chk("ign.busy_in_gap", 32'(busy), 32'd1);
    scan_req = 1'b1;
    @(negedge clk);
    scan_req = 1'b0;
    got = 0;
    for (int k = 0; k < G + 20 && !got; k++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    chk("ign.busy_fall", 32'(got), 32'd1);
    repeat (8 * H + 20) @(negedge clk);
    #1;
    chk("ign.one_valid", 32'(nvalid), 32'(nv + 1));
    chk("ign.still_idle", 32'(busy), 32'd0);
    chk("ign.buttons", 32'(buttons), 32'h058);

    run_scan("after_ign", 0, 12'h021, 12'h021, 6'b011110,
             1'b0, 1'b0, 12'h000, -1);

    // pad changes between p0 and p6: low byte from the old
    // state, mode/x/y/z from the new one, all at one edge
    run_scan("glitch", 2, 12'h35A, 12'hC5A, 6'b100101,
             1'b1, 1'b1, 12'hC21, 3);

    // randomized against the pad-level reference
    for (int i = 0; i < 16; i++) begin
      rt = int'($urandom_range(0, 2));
      rb = legal(12'($urandom));
      run_scan($sformatf("rnd%0d", i), rt, rb, exp_btn(rt, rb),
               ~rb[5:0], rt != 0, rt == 2, 12'h000, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
